// File: rtl/cirno9_ram4ls_ctrl.sv
// Load/store controller between the cirno9 core data port and a 32-bit synchronous SRAM.
// One access in flight at a time; configurable wait states; out-of-range accesses flagged.
module cirno9_ram4ls_ctrl #(
  parameter int unsigned     WAIT_CYC  = 0,
  parameter longint unsigned MEM_BYTES = 65536,
  parameter logic [31:0]     ERR_RDAT  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ren,
  input  logic [3:0]  i_wen,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  output logic [31:0] o_rdat,
  output logic        o_rdy,
  output logic        o_err,
  output logic        o_sram_en,
  output logic [3:0]  o_sram_we,
  output logic [31:0] o_sram_adr,
  output logic [31:0] o_sram_din,
  input  logic [31:0] i_sram_dout
);

  // Handshake: o_rdy=1 means the controller is idle; a request (i_ren or any i_wen bit)
  // seen at a clock edge while o_rdy=1 is accepted, and the core holds it stable while o_rdy=0.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  wen_q;
  logic        oor_q;
  logic        req;
  logic        oor;
  logic        accept;

  assign req    = i_ren | (|i_wen);
  assign oor    = {1'b0, i_adr} >= 33'(MEM_BYTES);
  assign accept = (state == S_IDLE) && req;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = oor ? S_CAPT : S_ISSUE;
      S_ISSUE: state_nxt = (WAIT_CYC > 0) ? S_WAIT : S_CAPT;
      S_WAIT:  if (cnt == 4'(WAIT_CYC)) state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_rdy     = (state == S_IDLE);
    o_sram_en = (state == S_ISSUE);
    o_sram_we = (state == S_ISSUE) ? wen_q : 4'h0;
  end

  // Address/data stay latched until the next acceptance so the SRAM inputs never wiggle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= 4'h0;
      wen_q      <= 4'h0;
      oor_q      <= 1'b0;
      o_rdat     <= 32'h0;
      o_err      <= 1'b0;
      o_sram_adr <= 32'h0;
      o_sram_din <= 32'h0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          wen_q      <= i_wen;
          oor_q      <= oor;
          o_err      <= 1'b0;
          o_sram_adr <= i_adr & 32'hFFFF_FFFC;
          o_sram_din <= i_wdat;
        end
        S_ISSUE: cnt <= 4'h1;
        S_WAIT:  cnt <= cnt + 4'h1;
        S_CAPT: begin
          cnt <= 4'h0;
          if (oor_q) o_err <= 1'b1;
          if (wen_q == 4'h0) o_rdat <= oor_q ? ERR_RDAT : i_sram_dout;
        end
        default: cnt <= 4'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_cirno9_ram4ls_ctrl.sv
// Bench for cirno9_ram4ls_ctrl: two instances (0 and 3 wait states), each with its own SRAM
// model, checked against a transaction-level reference memory and latency rules.
module tb_cirno9_ram4ls_ctrl;

  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
  localparam int          WORDS   = 16384;

  logic        clk;
  logic        rst_n     [2];
  logic        ren       [2];
  logic [3:0]  wen       [2];
  logic [31:0] adr       [2];
  logic [31:0] wdat      [2];
  logic [31:0] rdat      [2];
  logic        rdy       [2];
  logic        err       [2];
  logic        sram_en   [2];
  logic [3:0]  sram_we   [2];
  logic [31:0] sram_adr  [2];
  logic [31:0] sram_din  [2];
  logic [31:0] sram_dout [2];

  logic [31:0] sram_mem [2][WORDS];
  logic [31:0] ref_mem  [2][WORDS];
  logic [31:0] exp_rdat [2];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cirno9_ram4ls_ctrl #(
      .WAIT_CYC (g == 0 ? 0 : 3),
      .MEM_BYTES(65536),
      .ERR_RDAT (ERR_VAL)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .i_ren      (ren[g]),
      .i_wen      (wen[g]),
      .i_adr      (adr[g]),
      .i_wdat     (wdat[g]),
      .o_rdat     (rdat[g]),
      .o_rdy      (rdy[g]),
      .o_err      (err[g]),
      .o_sram_en  (sram_en[g]),
      .o_sram_we  (sram_we[g]),
      .o_sram_adr (sram_adr[g]),
      .o_sram_din (sram_din[g]),
      .i_sram_dout(sram_dout[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int d, input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'(d);
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // SRAM models: strobes sampled mid-cycle, applied at the next rising edge.
  initial begin
    logic        en_s  [2];
    logic [3:0]  we_s  [2];
    logic [31:0] adr_s [2];
    logic [31:0] din_s [2];
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < WORDS; i++) sram_mem[d][i] = init_word(d, i);
      sram_dout[d] = 32'h0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        en_s[d] = sram_en[d]; we_s[d] = sram_we[d];
        adr_s[d] = sram_adr[d]; din_s[d] = sram_din[d];
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (en_s[d]) begin
          for (int b = 0; b < 4; b++)
            if (we_s[d][b]) sram_mem[d][adr_s[d][15:2]][8*b +: 8] = din_s[d][8*b +: 8];
          sram_dout[d] <= sram_mem[d][adr_s[d][15:2]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver + model: starts at a falling edge with the DUT idle, ends at the falling edge
  // where o_rdy is back, so a following call is a back-to-back request.
  task automatic do_txn(input int d, input logic r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        oor;
    int          lat_exp;
    int          k;
    int          en_cnt;
    logic [3:0]  we_seen;
    logic [31:0] adr_seen;
    logic [31:0] din_seen;
    oor      = (a >= 32'h0001_0000);
    lat_exp  = oor ? 2 : 3 + wait_of(d);
    k        = 0;
    en_cnt   = 0;
    we_seen  = 4'h0;
    adr_seen = 32'h0;
    din_seen = 32'h0;
    check("rdy_before_req", 32'(rdy[d]), 32'h1);
    ren[d] = r; wen[d] = w; adr[d] = a; wdat[d] = wd;
    if (w != 4'h0) begin
      if (!oor)
        for (int b = 0; b < 4; b++)
          if (w[b]) ref_mem[d][a[15:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      exp_rdat[d] = oor ? ERR_VAL : ref_mem[d][a[15:2]];
    end
    exp_q.push_back(exp_rdat[d]);
    do begin
      @(negedge clk);
      k++;
      if (sram_en[d]) begin
        en_cnt++;
        we_seen = sram_we[d]; adr_seen = sram_adr[d]; din_seen = sram_din[d];
      end
    end while (!rdy[d] && k < 40);
    check("latency", 32'(k), 32'(lat_exp));
    check("strobe_count", 32'(en_cnt), oor ? 32'h0 : 32'h1);
    if (!oor) begin
      check("sram_we", 32'(we_seen), 32'(w));
      check("sram_adr", adr_seen, a & 32'hFFFF_FFFC);
      if (w != 4'h0) check("sram_din", din_seen, wd);
    end
    check("rdat", rdat[d], exp_q.pop_front());
    check("err", 32'(err[d]), 32'(oor));
    ren[d] = 1'b0; wen[d] = 4'h0;
  endtask

  initial begin
    logic        r;
    logic [3:0]  w;
    logic [31:0] a;
    int          d;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; ren[i] = 1'b0; wen[i] = 4'h0; adr[i] = 32'h0; wdat[i] = 32'h0;
      exp_rdat[i] = 32'h0;
      for (int j = 0; j < WORDS; j++) ref_mem[i][j] = init_word(i, j);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_rdy", 32'(rdy[i]), 32'h1);
      check("rst_err", 32'(err[i]), 32'h0);
      check("rst_rdat", rdat[i], 32'h0);
      check("rst_en", 32'(sram_en[i]), 32'h0);
      check("rst_we", 32'(sram_we[i]), 32'h0);
      check("rst_adr", sram_adr[i], 32'h0);
      check("rst_din", sram_din[i], 32'h0);
      rst_n[i] = 1'b1;
    end
    @(negedge clk);

    // directed
    do_txn(0, 1'b0, 4'hF, 32'h10, 32'hA5A5_1234);
    do_txn(0, 1'b1, 4'h0, 32'h12, 32'h0);
    do_txn(0, 1'b0, 4'b0100, 32'h20, 32'h00CC_0000);
    do_txn(0, 1'b1, 4'h0, 32'h20, 32'h0);
    check("byte2_readback", 32'(rdat[0][23:16]), 32'hCC);
    do_txn(0, 1'b1, 4'hF, 32'h24, 32'h1357_9BDF);
    do_txn(0, 1'b1, 4'h0, 32'h0001_0000, 32'h0);
    do_txn(0, 1'b1, 4'h0, 32'h24, 32'h0);
    do_txn(1, 1'b1, 4'h0, 32'h30, 32'h0);
    do_txn(1, 1'b1, 4'h0, 32'h34, 32'h0);
    do_txn(1, 1'b0, 4'h3, 32'h0001_2344, 32'hFFFF_FFFF);

    // reset during WAIT
    ren[1] = 1'b1; adr[1] = 32'h40;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 32'(rdy[1]), 32'h0);
    rst_n[1] = 1'b0;
    @(negedge clk);
    check("midrst_rdy", 32'(rdy[1]), 32'h1);
    check("midrst_en", 32'(sram_en[1]), 32'h0);
    check("midrst_rdat", rdat[1], 32'h0);
    check("midrst_err", 32'(err[1]), 32'h0);
    ren[1] = 1'b0; rst_n[1] = 1'b1; exp_rdat[1] = 32'h0;
    @(negedge clk);

    // random
    for (int n = 0; n < 80; n++) begin
      d = int'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if (!r && w == 4'h0) r = 1'b1;
      if ($urandom_range(0, 7) == 0) a = 32'h0001_0000 + $urandom_range(0, 32'h00FF_0000);
      else                           a = 32'($urandom_range(0, 255));
      do_txn(d, r, w, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
